// File: rtl/frog_controller.sv
// Frog position and life-state controller: turns keypresses into single-cell hops,
// rides river logs, and latches isDead/isAlive until the game-flow block pulses respawn.
module frog_controller #(
    parameter int GRID_COLS  = 13,
    parameter int GRID_ROWS  = 13,
    parameter int START_COL  = 6,
    parameter int START_ROW  = 12,
    parameter int HOME_ROW   = 0,
    parameter int RIVER_TOP  = 1,
    parameter int RIVER_BOT  = 5,
    parameter int HOP_FRAMES = 8
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         frame_clk,
    input  logic [7:0]                   keycode,
    input  logic                         respawn,
    input  logic                         hazard_hit,
    input  logic                         on_log,
    input  logic                         log_step,
    input  logic                         log_dir,
    output logic [$clog2(GRID_COLS)-1:0] frog_x,
    output logic [$clog2(GRID_ROWS)-1:0] frog_y,
    output logic                         isDead,
    output logic                         isAlive,
    output logic [7:0]                   hop_count,
    output logic [1:0]                   fsm_state
);

    localparam int XW = $clog2(GRID_COLS);
    localparam int YW = $clog2(GRID_ROWS);

    localparam logic [XW-1:0] X_MAX   = XW'(GRID_COLS - 1);
    localparam logic [XW-1:0] X_START = XW'(START_COL);
    localparam logic [YW-1:0] Y_MAX   = YW'(GRID_ROWS - 1);
    localparam logic [YW-1:0] Y_START = YW'(START_ROW);
    localparam logic [YW-1:0] Y_HOME  = YW'(HOME_ROW);
    localparam logic [YW-1:0] Y_RTOP  = YW'(RIVER_TOP);
    localparam logic [YW-1:0] Y_RBOT  = YW'(RIVER_BOT);
    localparam logic [7:0]    COOL_INIT = 8'(HOP_FRAMES - 1);

    localparam logic [7:0] KEY_UP    = 8'h1A;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;

    // Encoding is visible on fsm_state, so keep it fixed.
    typedef enum logic [1:0] {
        READY = 2'd0,
        HOP   = 2'd1,
        DEAD  = 2'd2,
        HOME  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            dead_q, dead_d;
    logic            alive_q, alive_d;
    logic [7:0]      hop_q, hop_d;
    logic [7:0]      cool_q, cool_d;
    logic [7:0]      prev_q, prev_d;
    logic            sync1_q, sync2_q, sync3_q;

    logic            frame_tick;
    logic            in_river;
    logic            log_fall;
    logic [XW-1:0]   shift_x;
    logic [XW-1:0]   tgt_x;
    logic [YW-1:0]   tgt_y;
    logic            tgt_ok;
    logic            hop_req;

    assign frame_tick = sync2_q & ~sync3_q;
    assign in_river   = (y_q >= Y_RTOP) && (y_q <= Y_RBOT);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dead_d   = dead_q;
        alive_d  = alive_q;
        hop_d    = hop_q;
        cool_d   = cool_q;
        prev_d   = frame_tick ? keycode : prev_q;
        shift_x  = x_q;
        log_fall = 1'b0;
        tgt_x    = x_q;
        tgt_y    = y_q;
        tgt_ok   = 1'b0;

        // Log carry is applied first so a same-edge hop starts from the carried column.
        if (log_step && (state_q == READY || state_q == HOP) && in_river && on_log) begin
            if (log_dir) begin
                if (x_q == X_MAX) log_fall = 1'b1;
                else              shift_x  = x_q + XW'(1);
            end else begin
                if (x_q == '0) log_fall = 1'b1;
                else           shift_x  = x_q - XW'(1);
            end
        end
        x_d   = shift_x;
        tgt_x = shift_x;

        case (keycode)
            KEY_UP:    if (y_q != '0)         begin tgt_y = y_q - YW'(1);         tgt_ok = 1'b1; end
            KEY_DOWN:  if (y_q != Y_MAX)      begin tgt_y = y_q + YW'(1);         tgt_ok = 1'b1; end
            KEY_LEFT:  if (shift_x != '0)     begin tgt_x = shift_x - XW'(1);     tgt_ok = 1'b1; end
            KEY_RIGHT: if (shift_x != X_MAX)  begin tgt_x = shift_x + XW'(1);     tgt_ok = 1'b1; end
            default: ;
        endcase
        hop_req = tgt_ok && (keycode != prev_q);

        if (log_fall) begin
            state_d = DEAD;
            dead_d  = 1'b1;
        end else if (frame_tick) begin
            case (state_q)
                READY: begin
                    if (hazard_hit || (in_river && !on_log)) begin
                        state_d = DEAD;
                        dead_d  = 1'b1;
                    end else if (hop_req) begin
                        x_d    = tgt_x;
                        y_d    = tgt_y;
                        hop_d  = (hop_q == 8'hFF) ? hop_q : hop_q + 8'd1;
                        cool_d = COOL_INIT;
                        if (tgt_y == Y_HOME) begin
                            state_d = HOME;
                            alive_d = 1'b1;
                        end else if (HOP_FRAMES == 1) begin
                            state_d = READY;
                        end else begin
                            state_d = HOP;
                        end
                    end
                end
                HOP: begin
                    // Airborne: no river check and no key handling until cooldown expires.
                    if (hazard_hit) begin
                        state_d = DEAD;
                        dead_d  = 1'b1;
                    end else if (cool_q == 8'd1) begin
                        state_d = READY;
                        cool_d  = 8'd0;
                    end else begin
                        cool_d = cool_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end

        if (respawn) begin
            state_d = READY;
            x_d     = X_START;
            y_d     = Y_START;
            dead_d  = 1'b0;
            alive_d = 1'b0;
            hop_d   = 8'd0;
            cool_d  = 8'd0;
            prev_d  = keycode;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= READY;
            x_q     <= X_START;
            y_q     <= Y_START;
            dead_q  <= 1'b0;
            alive_q <= 1'b0;
            hop_q   <= 8'd0;
            cool_q  <= 8'd0;
            prev_q  <= 8'd0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dead_q  <= dead_d;
            alive_q <= alive_d;
            hop_q   <= hop_d;
            cool_q  <= cool_d;
            prev_q  <= prev_d;
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign frog_x    = x_q;
    assign frog_y    = y_q;
    assign isDead    = dead_q;
    assign isAlive   = alive_q;
    assign hop_count = hop_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_frog_controller.sv
// Bench for frog_controller: a reference model pushes expected snapshots per event,
// which are popped and compared once the DUT has had time to respond.
module tb_frog_controller;

    localparam int GRID = 13;
    localparam int HF   = 8;
    localparam logic [1:0] S_READY = 2'd0;
    localparam logic [1:0] S_HOP   = 2'd1;
    localparam logic [1:0] S_DEAD  = 2'd2;
    localparam logic [1:0] S_HOME  = 2'd3;

    logic       Clk        = 1'b0;
    logic       Reset_n    = 1'b0;
    logic       frame_clk  = 1'b0;
    logic [7:0] keycode    = 8'h00;
    logic       respawn    = 1'b0;
    logic       hazard_hit = 1'b0;
    logic       on_log     = 1'b0;
    logic       log_step   = 1'b0;
    logic       log_dir    = 1'b0;
    logic [3:0] frog_x;
    logic [3:0] frog_y;
    logic       isDead;
    logic       isAlive;
    logic [7:0] hop_count;
    logic [1:0] fsm_state;

    frog_controller dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .keycode    (keycode),
        .respawn    (respawn),
        .hazard_hit (hazard_hit),
        .on_log     (on_log),
        .log_step   (log_step),
        .log_dir    (log_dir),
        .frog_x     (frog_x),
        .frog_y     (frog_y),
        .isDead     (isDead),
        .isAlive    (isAlive),
        .hop_count  (hop_count),
        .fsm_state  (fsm_state)
    );

    // Clock / reset
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];

    // Reference model state
    logic [1:0] m_state;
    int         m_x, m_y, m_hop, m_cool;
    logic       m_dead, m_alive;
    logic [7:0] m_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] pack_model();
        return {m_state, 4'(m_x), 4'(m_y), m_dead, m_alive, 8'(m_hop)};
    endfunction

    function automatic logic [19:0] pack_dut();
        return {fsm_state, frog_x, frog_y, isDead, isAlive, hop_count};
    endfunction

    task automatic m_start(input logic [7:0] key);
        m_state = S_READY; m_x = 6; m_y = 12; m_dead = 1'b0; m_alive = 1'b0;
        m_hop = 0; m_cool = 0; m_prev = key;
    endtask

    function automatic bit m_river();
        return (m_y >= 1) && (m_y <= 5);
    endfunction

    task automatic m_die();
        m_state = S_DEAD;
        m_dead  = 1'b1;
    endtask

    task automatic m_log(input logic dir);
        int nx;
        if ((m_state == S_READY || m_state == S_HOP) && m_river() && on_log) begin
            nx = dir ? m_x + 1 : m_x - 1;
            if (nx < 0 || nx >= GRID) m_die();
            else                      m_x = nx;
        end
    endtask

    task automatic m_tick(input logic [7:0] key, input logic haz);
        int dx, dy, tx, ty;
        bit dir_key;
        dx = 0; dy = 0; dir_key = 1'b1;
        case (key)
            8'h1A:   dy = -1;
            8'h16:   dy = 1;
            8'h04:   dx = -1;
            8'h07:   dx = 1;
            default: dir_key = 1'b0;
        endcase
        if (m_state == S_READY) begin
            if (haz) m_die();
            else if (m_river() && !on_log) m_die();
            else if (dir_key && key != m_prev) begin
                tx = m_x + dx;
                ty = m_y + dy;
                if (tx >= 0 && tx < GRID && ty >= 0 && ty < GRID) begin
                    m_x = tx;
                    m_y = ty;
                    if (m_hop < 255) m_hop++;
                    m_cool = HF - 1;
                    if (m_y == 0) begin
                        m_state = S_HOME;
                        m_alive = 1'b1;
                    end else begin
                        m_state = S_HOP;
                    end
                end
            end
        end else if (m_state == S_HOP) begin
            if (haz) m_die();
            else if (m_cool == 1) m_state = S_READY;
            else m_cool--;
        end
        m_prev = key;
    endtask

    task automatic sb_compare(input string tag);
        logic [19:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(pack_dut()), 32'(e));
        end
    endtask

    // Driver tasks
    task automatic do_frame(input logic [7:0] key, input logic haz, input logic lstep, input logic ldir);
        @(negedge Clk);
        keycode    = key;
        hazard_hit = haz;
        frame_clk  = 1'b1;
        if (lstep) m_log(ldir);
        m_tick(key, haz);
        exp_q.push_back(pack_model());
        repeat (2) @(negedge Clk);
        if (lstep) begin
            log_step = 1'b1;
            log_dir  = ldir;
        end
        @(negedge Clk);
        log_step = 1'b0;
        @(negedge Clk);
        frame_clk  = 1'b0;
        hazard_hit = 1'b0;
        repeat (3) @(negedge Clk);
        sb_compare("frame");
    endtask

    task automatic hop(input logic [7:0] key);
        do_frame(key, 1'b0, 1'b0, 1'b0);
        repeat (HF - 1) do_frame(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_log(input logic dir);
        @(negedge Clk);
        log_step = 1'b1;
        log_dir  = dir;
        m_log(dir);
        exp_q.push_back(pack_model());
        @(negedge Clk);
        log_step = 1'b0;
        sb_compare("log");
    endtask

    task automatic do_respawn(input logic [7:0] key, input logic haz);
        @(negedge Clk);
        keycode    = key;
        hazard_hit = haz;
        respawn    = 1'b1;
        m_start(key);
        exp_q.push_back(pack_model());
        @(negedge Clk);
        respawn    = 1'b0;
        hazard_hit = 1'b0;
        sb_compare("respawn");
    endtask

    initial begin
        int hop_ticks;

        m_start(8'h00);
        repeat (3) @(negedge Clk);
        exp_q.push_back(pack_model());
        sb_compare("reset");
        Reset_n = 1'b1;

        // Held key gives one hop, then 7 ticks airborne
        hop_ticks = 0;
        for (int i = 0; i < 20; i++) begin
            do_frame(8'h1A, 1'b0, 1'b0, 1'b0);
            if (fsm_state == S_HOP) hop_ticks++;
        end
        check("hold_hop_ticks", 32'(hop_ticks), 32'd7);
        check("hold_y", 32'(frog_y), 32'd11);
        check("hold_hops", 32'(hop_count), 32'd1);
        check("hold_state", 32'(fsm_state), 32'(S_READY));
        do_frame(8'h00, 1'b0, 1'b0, 1'b0);

        // Grid edges: right edge then left edge
        repeat (6) hop(8'h07);
        hop(8'h07);
        check("edge_right_x", 32'(frog_x), 32'd12);
        check("edge_right_hops", 32'(hop_count), 32'd7);
        check("edge_right_state", 32'(fsm_state), 32'(S_READY));
        repeat (12) hop(8'h04);
        hop(8'h04);
        check("edge_left_x", 32'(frog_x), 32'd0);
        check("edge_left_hops", 32'(hop_count), 32'd19);

        // Land in the river without a log: dies on the first READY tick
        on_log = 1'b0;
        repeat (6) hop(8'h1A);
        check("river_alive_after_hop", 32'(isDead), 32'd0);
        do_frame(8'h00, 1'b0, 1'b0, 1'b0);
        check("river_dead", 32'(isDead), 32'd1);
        on_log = 1'b1;
        do_frame(8'h07, 1'b0, 1'b0, 1'b0);
        do_log(1'b1);
        check("river_frozen_x", 32'(frog_x), 32'd0);
        check("river_frozen_y", 32'(frog_y), 32'd5);

        // Log ride, with a same-edge log shift and hop, then carried off the grid
        do_respawn(8'h00, 1'b0);
        on_log = 1'b1;
        repeat (4) hop(8'h07);
        repeat (8) hop(8'h1A);
        do_frame(8'h1A, 1'b0, 1'b1, 1'b1);
        repeat (HF - 1) do_frame(8'h00, 1'b0, 1'b0, 1'b0);
        check("coincide_x", 32'(frog_x), 32'd11);
        check("coincide_y", 32'(frog_y), 32'd3);
        do_log(1'b1);
        check("log_x12", 32'(frog_x), 32'd12);
        do_log(1'b1);
        check("log_fall_dead", 32'(isDead), 32'd1);
        check("log_fall_x", 32'(frog_x), 32'd12);

        // Reach home, then respawn overriding a same-cycle hazard with key held
        do_respawn(8'h00, 1'b0);
        repeat (12) hop(8'h1A);
        check("home_alive", 32'(isAlive), 32'd1);
        check("home_dead", 32'(isDead), 32'd0);
        check("home_state", 32'(fsm_state), 32'(S_HOME));
        do_respawn(8'h1A, 1'b1);
        check("respawn_flags", 32'({isDead, isAlive}), 32'd0);
        do_frame(8'h1A, 1'b0, 1'b0, 1'b0);
        check("held_no_hop_y", 32'(frog_y), 32'd12);

        // Hazard beats a new key press in READY
        do_frame(8'h04, 1'b1, 1'b0, 1'b0);
        check("hazard_dead", 32'(fsm_state), 32'(S_DEAD));
        check("hazard_x", 32'(frog_x), 32'd6);

        // Asynchronous reset in the middle of a hop
        do_respawn(8'h00, 1'b0);
        on_log = 1'b0;
        do_frame(8'h1A, 1'b0, 1'b0, 1'b0);
        repeat (3) do_frame(8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        m_start(8'h00);
        exp_q.push_back(pack_model());
        #1;
        sb_compare("async_reset");
        @(negedge Clk);
        Reset_n = 1'b1;
        do_frame(8'h16, 1'b0, 1'b0, 1'b0);
        do_frame(8'h1A, 1'b0, 1'b0, 1'b0);
        check("post_reset_y", 32'(frog_y), 32'd11);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
